pkt_checker: RTL and testbench
==============================

PKT_CHECKER -- requirements
Module: pkt_checker

Interface
REQ-001 Parameter WIDTH, default 8, data/beat width in bits.
REQ-002 Parameter MAX_LEN, default 14, max payload beats per packet; integration SHALL keep MAX_LEN <= downstream speculative FIFO DEPTH-1.
REQ-003 Parameter MIN_LEN, default 1, min payload beats for a good packet.
REQ-004 clk  input  1  clock; all state SHALL update on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream beat valid.
REQ-007 in_ready  output  1  upstream beat accepted when in_valid && in_ready.
REQ-008 in_data  input  WIDTH  upstream beat data.
REQ-009 in_last  input  1  beat is the packet's checksum beat (final beat).
REQ-010 out_valid  output  1  payload write request to speculative FIFO.
REQ-011 out_ready  input  1  speculative FIFO can accept (not full).
REQ-012 out_data  output  WIDTH  payload beat, SHALL equal in_data combinationally.
REQ-013 commit  output  1  one-cycle pulse, packet good, make writes visible.
REQ-014 revert  output  1  one-cycle pulse, packet bad, discard uncommitted writes.
REQ-015 err_csum  output  1  one-cycle pulse with revert, checksum mismatch.
REQ-016 err_len  output  1  one-cycle pulse with revert, length < MIN_LEN or > MAX_LEN.
REQ-017 pkt_ok_cnt  output  16  good-packet count, saturating at 0xFFFF.
REQ-018 pkt_bad_cnt  output  16  bad-packet count, saturating at 0xFFFF.

Function
REQ-019 FSM states SHALL be RECV, DROP, FLAG; state, len counter, running sum SHALL be registered.
REQ-020 Packet = 0..N payload beats (in_last=0) then one checksum beat (in_last=1); checksum beat SHALL never be written downstream.
REQ-021 Good packet: MIN_LEN <= len <= MAX_LEN and (sum of payload + checksum) mod 2^WIDTH == 0.
REQ-022 RECV, in_last=0, len < MAX_LEN: out_valid=in_valid, in_ready=out_ready; on handshake sum += in_data (mod 2^WIDTH), len += 1.
REQ-023 RECV, in_last=0, len == MAX_LEN: out_valid=0, in_ready=1; on accept beat discarded, next state DROP.
REQ-024 RECV, in_last=1: out_valid=0, in_ready=1 regardless of out_ready; on accept evaluate REQ-021, latch ok/err flags, next state FLAG.
REQ-025 DROP: out_valid=0, in_ready=1; beats discarded; on accepted in_last=1 latch err_len, next state FLAG.
REQ-026 FLAG (exactly one cycle): in_ready=0, out_valid=0; commit=ok, revert=!ok; err_len if length bad, err_csum if length ok and sum bad (length error takes priority, never both); increment matching counter; clear sum and len; next state RECV.
REQ-027 commit and revert SHALL never both be 1; neither SHALL coincide with out_valid=1.
REQ-028 Zero-payload packet (first beat in_last=1) with MIN_LEN>=1 SHALL produce revert + err_len.
REQ-029 Back-to-back packets SHALL cost exactly one bubble cycle (FLAG) between checksum beat and next payload beat.
REQ-030 len counter width SHALL be $clog2(MAX_LEN+1) and never wrap.

Reset
REQ-031 While reset=1: state=RECV, sum=0, len=0, counters=0, commit=revert=err_csum=err_len=0, out_valid=0.
REQ-032 Reset mid-packet SHALL abandon the packet with no commit/revert pulse; downstream FIFO is reset in the same cycle.

Verification
REQ-033 Payload 0x01,0x02 + checksum 0xFD, out_ready=1 -> two writes 0x01,0x02, commit pulse 1 cycle after checksum beat, pkt_ok_cnt=1.
REQ-034 Payload 0x01,0x02 + checksum 0x00 -> two writes, then revert + err_csum, pkt_bad_cnt=1, no commit.
REQ-035 MAX_LEN=14, 16 payload beats + checksum -> 14 writes, beats 15-16 consumed unwritten, revert + err_len.
REQ-036 Lone in_last beat 0x00 -> no writes, revert + err_len, pkt_bad_cnt=1.
REQ-037 Good 3-beat packet with out_ready low on beat 2 for 3 cycles -> in_ready low 3 cycles, no beat lost/duplicated, commit after checksum.
REQ-038 Reset asserted after 2 payload beats -> no commit/revert; next good packet commits, pkt_ok_cnt=1.

Source files
------------

// File: rtl/pkt_checker.sv
// pkt_checker: validates length and checksum of packets streamed into a speculative FIFO, then commits or reverts them.
module pkt_checker #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 14,
  parameter int MIN_LEN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             commit,
  output logic             revert,
  output logic             err_csum,
  output logic             err_len,
  output logic [15:0]      pkt_ok_cnt,
  output logic [15:0]      pkt_bad_cnt
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [1:0] RECV = 2'd0, DROP = 2'd1, FLAG = 2'd2;
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN), MIN_L = LW'(MIN_LEN);
  logic [1:0]       state;
  logic [LW-1:0]    len;
  logic [WIDTH-1:0] sum, csum;
  logic             ok, len_bad, pay, acc, len_ok, flag;
  always_comb begin
    pay       = state == RECV && !in_last && len != MAX_L;
    in_ready  = state == FLAG ? 1'b0 : pay ? out_ready : 1'b1;
    out_valid = !reset && pay && in_valid;
    acc       = in_valid && in_ready;
    csum      = sum + in_data;
    len_ok    = len >= MIN_L;
    flag      = !reset && state == FLAG;
  end
  assign out_data = in_data;
  assign commit   = flag && ok;
  assign revert   = flag && !ok;
  assign err_len  = flag && len_bad;
  assign err_csum = flag && !ok && !len_bad;
  // Overflowing beats leave len parked at MAX_LEN; DROP remembers the length error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RECV;
      len         <= '0;
      sum         <= '0;
      ok          <= 1'b0;
      len_bad     <= 1'b0;
      pkt_ok_cnt  <= '0;
      pkt_bad_cnt <= '0;
    end else if (state == FLAG) begin
      state <= RECV;
      len   <= '0;
      sum   <= '0;
      if (ok && pkt_ok_cnt != 16'hFFFF) pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
      if (!ok && pkt_bad_cnt != 16'hFFFF) pkt_bad_cnt <= pkt_bad_cnt + 16'd1;
    end else if (acc && in_last) begin
      state   <= FLAG;
      ok      <= state == RECV && len_ok && csum == '0;
      len_bad <= state == DROP || !len_ok;
    end else if (acc && state == RECV) begin
      if (len == MAX_L) state <= DROP;
      else begin
        sum <= csum;
        len <= len + LW'(1);
      end
    end
  end
endmodule

// File: tb/tb_pkt_checker.sv
// tb_pkt_checker: directed scoreboard bench for pkt_checker (writes and commit/revert events).
module tb_pkt_checker;
  localparam int ML = 14;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_ready, out_valid, commit, revert, err_csum, err_len;
  logic [7:0]  out_data;
  logic [15:0] pkt_ok_cnt, pkt_bad_cnt;
  int          checks = 0, errors = 0;
  logic [7:0]  wq[$];
  logic [3:0]  eq[$];
  int          tb_len = 0, tb_ok = 0, tb_bad = 0;
  logic [7:0]  tb_sum = '0;
  logic        tb_over = 1'b0;

  pkt_checker #(.WIDTH(8), .MAX_LEN(ML), .MIN_LEN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .commit(commit), .revert(revert), .err_csum(err_csum), .err_len(err_len),
    .pkt_ok_cnt(pkt_ok_cnt), .pkt_bad_cnt(pkt_bad_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    chk("pulse_rules", {28'd0, commit && revert, (commit || revert) && out_valid,
        (err_csum || err_len) && !revert, err_csum && err_len}, 0);
    if (out_valid && out_ready) begin
      chk("write_pending", 32'(wq.size() > 0), 1);
      if (wq.size() > 0) chk("write_data", out_data, wq.pop_front());
    end
    if (commit || revert) begin
      chk("event_pending", 32'(eq.size() > 0), 1);
      if (eq.size() > 0) chk("event", {commit, revert, err_csum, err_len}, eq.pop_front());
    end
  end

  // Model decides whether each beat is written and what the closing event must be.
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    logic rdy;
    logic good, lbad;
    if (!l) begin
      if (tb_len < ML) begin
        wq.push_back(d);
        tb_len++;
        tb_sum += d;
      end else tb_over = 1'b1;
    end else begin
      lbad = tb_over || tb_len < 1;
      good = !lbad && 8'(tb_sum + d) == 8'd0;
      eq.push_back({good, !good, !good && !lbad, lbad});
      if (good) tb_ok++; else tb_bad++;
      tb_len = 0;
      tb_sum = '0;
      tb_over = 1'b0;
    end
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    chk("accept", rdy, 1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic finish_pkt(input logic exp_commit);
    @(negedge clk);
    chk("commit_timing", commit, exp_commit);
    chk("revert_timing", revert, !exp_commit);
    @(negedge clk);
    chk("pkt_ok_cnt", pkt_ok_cnt, tb_ok);
    chk("pkt_bad_cnt", pkt_bad_cnt, tb_bad);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pulses", {commit, revert, err_csum, err_len}, 0);
    chk("rst_ok_cnt", pkt_ok_cnt, 0);
    chk("rst_bad_cnt", pkt_bad_cnt, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    // good 2-beat packet, with the FLAG bubble probed by a waiting next beat
    send(8'h01, 0); send(8'h02, 0); send(8'hFD, 1);
    in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    chk("bubble_in_ready", in_ready, 0);
    chk("bubble_commit", commit, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("ok_cnt_1", pkt_ok_cnt, 1);
    @(posedge clk);
    #1;
    send(8'h01, 0); send(8'h02, 0); send(8'h00, 1);
    finish_pkt(0);
    for (int i = 1; i <= 16; i++) send(8'(i), 0);
    send(8'h00, 1);
    finish_pkt(0);
    send(8'h00, 1);
    finish_pkt(0);
    for (int i = 0; i < ML; i++) send(8'h01, 0);
    send(8'hF2, 1);
    finish_pkt(1);
    send(8'h80, 0); send(8'h80, 1);
    finish_pkt(1);
    send(8'h10, 0);
    fork
      send(8'h20, 0);
      begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    send(8'h30, 0); send(8'hA0, 1);
    finish_pkt(1);
    send(8'h07, 0); send(8'h08, 0);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_pulses", {commit, revert, out_valid}, 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    tb_len = 0; tb_sum = '0; tb_over = 1'b0; tb_ok = 0; tb_bad = 0;
    send(8'h05, 0); send(8'hFB, 1);
    finish_pkt(1);
    chk("write_q_empty", wq.size(), 0);
    chk("event_q_empty", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
